load_store_unit: RTL and testbench

Memory-stage load/store unit sitting directly downstream of the ALU. It takes the ALU result as the effective address, drives a request/grant/response data-memory port with byte enables, and returns aligned, sign- or zero-extended load data. While an access is in flight it stalls the upstream pipeline. It is a multi-cycle FSM, so variable-latency memories are handled without pipeline-wide changes.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/load_align.sv | 27 ++
 rtl/load_store_unit.sv | 125 ++++++++++++
 tb/tb_load_store_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state type, Funct3 codes and request legality helpers for the LSU
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Loads accept signed and unsigned sizes; stores only carry B/H/W.
  function automatic logic f3_supported(input logic is_load, input logic [2:0] f3);
    if (is_load) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                        (f3 == F3_BU) || (f3 == F3_HU);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

  // Halves need an even address, words a 4-byte aligned address.
  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_H, F3_HU: return ~a[0];
      F3_W:        return (a == 2'b00);
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed lane of a read word and extends it to 32 bits
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the lane, then sign- or zero-extend according to the access size.
  always_comb begin
    byte_lane = rdata_i[8*addr_i +: 8];
    half_lane = rdata_i[16*addr_i[1] +: 16];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    data_o = {{16{half_lane[15]}}, half_lane};
      F3_BU:   data_o = {24'd0, byte_lane};
      F3_HU:   data_o = {16'd0, half_lane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit with req/gnt/rvalid data port and pipeline stall
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] StoreData,
  output logic                  Stall,
  output logic [DATA_WIDTH-1:0] LoadData,
  output logic                  LoadValid,
  output logic                  Misaligned,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);

  lsu_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [2:0]            f3_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] load_data_q;
  logic [DATA_WIDTH-1:0] aligned_data;
  logic                  req_present, is_load, supported, aligned, accept;

  // Decode the incoming MEM-stage request; a load wins if both strobes are set.
  always_comb begin
    req_present = MemRead | MemWrite;
    is_load     = MemRead;
    supported   = f3_supported(is_load, Funct3);
    aligned     = f3_aligned(Funct3, ALUResult[1:0]);
    accept      = (state_q == IDLE) & req_present & supported & aligned;
    Misaligned  = (state_q == IDLE) & req_present & supported & ~aligned;
  end

  // Byte enables and lane-replicated store data; loads reuse the same enables.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = StoreData;
    case (Funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << ALUResult[1:0];
        wdata_d = {4{StoreData[7:0]}};
      end
      2'b01: begin
        be_d    = ALUResult[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{StoreData[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = StoreData;
      end
    endcase
  end

  // Next-state logic and FSM-derived outputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = REQ;
      REQ:  if (dmem_gnt) state_d = we_q ? DONE : WAIT;
      WAIT: if (dmem_rvalid) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    dmem_req  = (state_q == REQ);
    Stall     = accept | (state_q == REQ) | (state_q == WAIT);
    LoadValid = (state_q == DONE) & ~we_q;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Capture the accepted request so the memory port stays stable until granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= ALUResult;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= Funct3;
      we_q    <= ~is_load;
    end
  end

  load_align u_load_align (
    .rdata_i  (dmem_rdata),
    .addr_i   (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (aligned_data)
  );

  // Load result register, updated only when the read response arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              load_data_q <= '0;
    else if ((state_q == WAIT) && dmem_rvalid) load_data_q <= aligned_data;
  end

  assign LoadData   = load_data_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a behavioural memory/result model
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, StoreData;
  logic        Stall, LoadValid, Misaligned;
  logic [31:0] LoadData;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_ld = 32'd0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .ALUResult(ALUResult), .StoreData(StoreData),
    .Stall(Stall), .LoadData(LoadData), .LoadValid(LoadValid), .Misaligned(Misaligned),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle(input string nm);
    tick();
    MemRead = 0; MemWrite = 0; dmem_gnt = 0; dmem_rvalid = 0;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || Stall !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: req=%b stall=%b required 0 0", nm, dmem_req, Stall);
    end
  endtask

  // One complete access: drive the request, act as memory, check port and result.
  task automatic run_access(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sd, input int gd, input int rd,
                            input logic [31:0] rdata, input bit noise, input string nm);
    bit sup, legal, mis, granted, done, sgn;
    int sz, waited, since, stall_n, exp_stall;
    logic [31:0] exp_be, exp_wd, ext, sh;
    sup = ld ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 == 0 || f3 == 1 || f3 == 2);
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = sup && ((addr % sz) == 0);
    mis   = sup && ((addr % sz) != 0);
    exp_be = (sz == 1) ? (32'd1 << (addr % 4)) : (sz == 2) ? (32'd3 << (addr % 4)) : 32'd15;
    exp_wd = (sz == 1) ? (sd & 32'hFF) * 32'h0101_0101 :
             (sz == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
    sgn = (f3 == 0 || f3 == 1);
    sh  = rdata >> (8 * (addr % 4));
    if (sz == 1) begin
      ext = sh & 32'hFF;
      if (sgn && ext >= 128) ext = ext | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      ext = sh & 32'hFFFF;
      if (sgn && ext >= 32768) ext = ext | 32'hFFFF_0000;
    end else ext = rdata;
    exp_stall = ld ? (3 + gd + rd - 1) : (2 + gd);

    tick();
    MemRead = ld; MemWrite = ld ? 1'($urandom_range(0, 1)) : 1'b1;
    Funct3 = f3; ALUResult = addr; StoreData = sd;
    dmem_gnt = 0; dmem_rvalid = 0;
    @(negedge clk);
    checks++;
    if (Stall !== legal) begin
      errors++; $display("FAIL %s_accept_stall: got %b required %b", nm, Stall, legal);
    end
    checks++;
    if (Misaligned !== mis) begin
      errors++; $display("FAIL %s_misaligned: got %b required %b", nm, Misaligned, mis);
    end
    if (!legal) begin
      tick();
      MemRead = 0; MemWrite = 0;
      @(negedge clk);
      checks++;
      if (Misaligned !== 1'b0 || dmem_req !== 1'b0 || Stall !== 1'b0 || LoadData !== model_ld) begin
        errors++;
        $display("FAIL %s_rejected: mis=%b req=%b stall=%b ld=%h required 0 0 0 %h",
                 nm, Misaligned, dmem_req, Stall, LoadData, model_ld);
      end
      return;
    end

    stall_n = 1; granted = 0; done = 0; waited = 0; since = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      tick();
      dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = $urandom;
      if (!granted) begin
        if (dmem_req) begin
          if (waited == gd) begin
            dmem_gnt = 1; granted = 1;
            if (noise && ld) begin dmem_rvalid = 1; dmem_rdata = ~rdata; end
          end else waited++;
        end
      end else if (ld) begin
        since++;
        if (since == rd) begin dmem_rvalid = 1; dmem_rdata = rdata; end
      end
      @(negedge clk);
      if (dmem_req) begin
        checks++;
        if (dmem_addr !== (addr & 32'hFFFF_FFFC) || dmem_we !== !ld || dmem_be !== exp_be[3:0] ||
            (!ld && dmem_wdata !== exp_wd)) begin
          errors++;
          $display("FAIL %s_port: addr=%h we=%b be=%b wd=%h required %h %b %b %h",
                   nm, dmem_addr, dmem_we, dmem_be, dmem_wdata, addr & 32'hFFFF_FFFC, !ld, exp_be[3:0], exp_wd);
        end
      end
      if (Stall) begin
        stall_n++;
        if (LoadValid !== 1'b0) begin
          checks++; errors++; $display("FAIL %s_early_valid: got 1 required 0", nm);
        end
      end else begin
        done = 1;
        if (ld) model_ld = ext;
        checks++;
        if (LoadValid !== ld || dmem_req !== 1'b0) begin
          errors++;
          $display("FAIL %s_done: valid=%b req=%b required %b 0", nm, LoadValid, dmem_req, ld);
        end
        checks++;
        if (LoadData !== model_ld) begin
          errors++; $display("FAIL %s_loaddata: got %h required %h", nm, LoadData, model_ld);
        end
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL %s_timeout: access did not complete within 60 cycles", nm);
    end else if (stall_n != exp_stall) begin
      errors++; $display("FAIL %s_stall_cycles: got %0d required %0d", nm, stall_n, exp_stall);
    end
  endtask

  task automatic test_reset();
    reset_n = 0; MemRead = 0; MemWrite = 0; Funct3 = 0; ALUResult = 0; StoreData = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({Stall, LoadValid, Misaligned, dmem_req, dmem_we} !== 5'b0 || LoadData !== 0 ||
        dmem_addr !== 0 || dmem_wdata !== 0 || dmem_be !== 0) begin
      errors++;
      $display("FAIL reset_values: ctl=%b ld=%h addr=%h wd=%h be=%b required all zero",
               {Stall, LoadValid, Misaligned, dmem_req, dmem_we}, LoadData, dmem_addr, dmem_wdata, dmem_be);
    end
    reset_n = 1;
  endtask

  task automatic test_directed();
    run_access(1, 3'b000, 32'h1003, 32'h0, 0, 1, 32'h80FF_0000, 0, "lb");
    go_idle("lb");
    run_access(0, 3'b001, 32'h2002, 32'h1234_ABCD, 0, 1, 32'h0, 0, "sh");
    go_idle("sh");
    run_access(1, 3'b010, 32'h3000, 32'h0, 2, 3, 32'hDEAD_BEEF, 0, "lw_delay");
    go_idle("lw_delay");
    run_access(1, 3'b010, 32'h0006, 32'h0, 0, 1, 32'h0, 0, "lw_misaligned");
    run_access(1, 3'b011, 32'h0008, 32'h0, 0, 1, 32'h0, 0, "unsupported");
  endtask

  task automatic test_back_to_back();
    run_access(1, 3'b101, 32'h10, 32'h0, 0, 1, 32'h0000_F00D, 0, "b2b_lhu");
    run_access(0, 3'b000, 32'h11, 32'h0000_0077, 0, 1, 32'h0, 0, "b2b_sb");
    go_idle("b2b");
  endtask

  task automatic test_reset_mid_access(input bit in_wait, input string nm);
    tick();
    MemRead = 1; MemWrite = 0; Funct3 = 3'b010; ALUResult = 32'h40; dmem_gnt = 0; dmem_rvalid = 0;
    tick();
    if (in_wait) begin dmem_gnt = 1; tick(); dmem_gnt = 0; end
    #2;
    checks++;
    if (Stall !== 1'b1) begin
      errors++; $display("FAIL %s_pre: stall=%b required 1", nm, Stall);
    end
    MemRead = 0;
    reset_n = 0;
    #1;
    model_ld = 0;
    checks++;
    if (dmem_req !== 1'b0 || Stall !== 1'b0 || LoadData !== 32'd0 || LoadValid !== 1'b0) begin
      errors++;
      $display("FAIL %s_async: req=%b stall=%b ld=%h valid=%b required 0 0 0 0",
               nm, dmem_req, Stall, LoadData, LoadValid);
    end
    @(negedge clk);
    reset_n = 1;
    tick();
    dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++;
    if (LoadValid !== 1'b0 || Stall !== 1'b0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL %s_late_resp: valid=%b stall=%b req=%b required 0 0 0", nm, LoadValid, Stall, dmem_req);
    end
    tick();
    dmem_gnt = 0; dmem_rvalid = 0;
    @(negedge clk);
    checks++;
    if (LoadData !== 32'd0 || LoadValid !== 1'b0) begin
      errors++; $display("FAIL %s_ignored: ld=%h valid=%b required 0 0", nm, LoadData, LoadValid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(1, 3), $urandom, 1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 1) == 1) go_idle("rand");
    end
    go_idle("rand_end");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_access(1, "rst_wait");
    test_reset_mid_access(0, "rst_req");
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
